wb_mem_arbiter: RTL

Two-master Wishbone arbiter that shares the single physical-memory port between the L1 miss path (m0) and the stream prefetch buffer (m1). It sits between the two cache-side wishbone masters and the memory-side wishbone slave, and grants one 128-bit line transaction at a time with round-robin fairness. A watchdog converts a hung memory transaction into a retry to the owning master.

---
 rtl/wb_mem_arbiter_pkg.sv | 22 ++
 rtl/wb_arb_watchdog.sv | 32 +++
 rtl/wb_mem_arbiter.sv | 139 +++++++++++++
 3 files changed

// File: rtl/wb_mem_arbiter_pkg.sv
// Shared line-transaction types and owner encoding for the wishbone memory arbiter.
package wb_mem_arbiter_pkg;

    typedef logic [127:0] lc3b_line;
    typedef logic [11:0]  lc3b_line_addr;
    typedef logic [15:0]  lc3b_line_sel;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    // On contention the master that did not own the previous transaction wins.
    function automatic logic pick_owner(input logic req0, input logic req1, input logic last_owner);
        if (req0 && req1) begin
            return ~last_owner;
        end else if (req1) begin
            return OWNER_M1;
        end else begin
            return OWNER_M0;
        end
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Transaction watchdog: counts enabled cycles since the last clear and flags the
// TIMEOUT-th one.
module wb_arb_watchdog
    import wb_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expire
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != LAST)) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expire = i_enable & (r_count == LAST);

endmodule

// File: rtl/wb_mem_arbiter.sv
// Round-robin arbiter sharing the memory wishbone port between the L1 miss path (m0)
// and the stream buffer (m1). States: IDLE = arbitrate | BUSY = owner on bus | RELEASE = bubble.
module wb_mem_arbiter
    import wb_mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_m0_cyc,
    input  logic         i_m0_stb,
    input  logic         i_m0_we,
    input  logic [11:0]  i_m0_adr,
    input  logic [127:0] i_m0_dat,
    input  logic [15:0]  i_m0_sel,
    output logic [127:0] o_m0_dat,
    output logic         o_m0_ack,
    output logic         o_m0_rty,
    input  logic         i_m1_cyc,
    input  logic         i_m1_stb,
    input  logic         i_m1_we,
    input  logic [11:0]  i_m1_adr,
    input  logic [127:0] i_m1_dat,
    input  logic [15:0]  i_m1_sel,
    output logic [127:0] o_m1_dat,
    output logic         o_m1_ack,
    output logic         o_m1_rty,
    output logic         o_mem_cyc,
    output logic         o_mem_stb,
    output logic         o_mem_we,
    output logic [11:0]  o_mem_adr,
    output logic [127:0] o_mem_dat,
    output logic [15:0]  o_mem_sel,
    input  logic [127:0] i_mem_dat,
    input  logic         i_mem_ack,
    input  logic         i_mem_rty,
    output logic         o_timeout
);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} arb_state_t;

    arb_state_t    r_state;
    arb_state_t    w_next_state;
    logic          r_owner;
    logic          r_last_owner;
    logic          w_req0;
    logic          w_req1;
    logic          w_busy;
    logic          w_resp;
    logic          w_expire;
    logic          w_wd_rty;
    logic          w_own_cyc;
    logic          w_own_stb;
    logic          w_own_we;
    lc3b_line_addr w_own_adr;
    lc3b_line      w_own_dat;
    lc3b_line_sel  w_own_sel;

    assign w_req0 = i_m0_cyc & i_m0_stb;
    assign w_req1 = i_m1_cyc & i_m1_stb;
    assign w_busy = (r_state == BUSY);
    assign w_resp = i_mem_ack | i_mem_rty;

    assign w_own_cyc = (r_owner == OWNER_M1) ? i_m1_cyc : i_m0_cyc;
    assign w_own_stb = (r_owner == OWNER_M1) ? i_m1_stb : i_m0_stb;
    assign w_own_we  = (r_owner == OWNER_M1) ? i_m1_we  : i_m0_we;
    assign w_own_adr = (r_owner == OWNER_M1) ? i_m1_adr : i_m0_adr;
    assign w_own_dat = (r_owner == OWNER_M1) ? i_m1_dat : i_m0_dat;
    assign w_own_sel = (r_owner == OWNER_M1) ? i_m1_sel : i_m0_sel;

    // A real response in the expiry cycle wins; an aborting owner gets nothing.
    assign w_wd_rty = w_expire & ~w_resp & w_own_cyc;

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (~w_busy),
        .i_enable (w_busy),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_owner      <= OWNER_M0;
            r_last_owner <= OWNER_M1;
        end else begin
            r_state <= w_next_state;
            if ((r_state == IDLE) && (w_req0 || w_req1)) begin
                r_owner <= pick_owner(w_req0, w_req1, r_last_owner);
            end
            if (w_busy && (w_next_state == RELEASE)) begin
                r_last_owner <= r_owner;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_req0 || w_req1) w_next_state = BUSY;
            BUSY:    if (w_resp || !w_own_cyc || w_expire) w_next_state = RELEASE;
            RELEASE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        o_mem_cyc = 1'b0;
        o_mem_stb = 1'b0;
        o_mem_we  = w_own_we;
        o_mem_adr = w_own_adr;
        o_mem_dat = w_own_dat;
        o_mem_sel = w_own_sel;
        o_m0_ack  = 1'b0;
        o_m0_rty  = 1'b0;
        o_m1_ack  = 1'b0;
        o_m1_rty  = 1'b0;
        o_timeout = 1'b0;
        if (w_busy) begin
            o_mem_cyc = w_own_cyc;
            o_mem_stb = w_own_stb;
            o_timeout = w_wd_rty;
            if (r_owner == OWNER_M0) begin
                o_m0_ack = i_mem_ack;
                o_m0_rty = i_mem_rty | w_wd_rty;
            end else begin
                o_m1_ack = i_mem_ack;
                o_m1_rty = i_mem_rty | w_wd_rty;
            end
        end
    end

    assign o_m0_dat = i_mem_dat;
    assign o_m1_dat = i_mem_dat;

endmodule
